input_sequencer: RTL

INPUT_SEQUENCER -- requirements
Module: input_sequencer

---
 rtl/input_sequencer_pkg.sv | 30 +++
 rtl/input_sequencer_debounce_pulse.sv | 96 +++++++++
 rtl/input_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/input_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_sequencer_pkg
// Description : Types and constants shared by the input sequencer, the
//               downstream Moore machine and the display logic. Holds the
//               2-bit debounce FSM state encoding and the default debounce
//               length (20 ms at 50 MHz).
// Revision    : 1.0 - initial release
// ============================================================================
package input_sequencer_pkg;

  // Debounce FSM state encoding (2 bits, visible to other blocks)
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int FIFO_DEPTH_DEFAULT      = 8;
  localparam int FILL_W                  = 5;

  // The qualification counter only ever holds 0..DEBOUNCE_CYCLES-2
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage : input_sequencer_pkg
`default_nettype wire

// File: rtl/input_sequencer_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse
// Description : Two-flop synchronizer plus a four-state debounce FSM. A level
//               change is accepted only after DEBOUNCE_CYCLES consecutive
//               stable synchronized samples; any bounce restarts the count.
//               Emits one registered pulse per qualified press.
// Ports       : clk_in  - system clock
//               reset   - asynchronous, active-low reset
//               raw_i   - raw asynchronous active-high button
//               pulse_o - one-cycle pulse per accepted press (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_pulse
  import input_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // The counter clears on entry to a WAIT state and the transition is taken
  // on the sample that would bring it to DEBOUNCE_CYCLES-1, so the wait
  // spans exactly DEBOUNCE_CYCLES stable samples.
  localparam logic [CW-1:0] CNT_LAST =
      CW'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

  logic          sync1_q;
  logic          sync2_q;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync2_q) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!sync2_q) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync2_q) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;

endmodule : debounce_pulse
`default_nettype wire

// File: rtl/input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : input_sequencer
// Description : Debounces a push-button and, on each accepted press, queues
//               the synchronized slide-switch value into a small FIFO that a
//               downstream state machine drains one bit at a time.
// Ports       : clk_in      - system clock
//               reset       - asynchronous, active-low reset
//               btn_raw     - raw bouncing push-button (active-high)
//               sw_raw      - raw slide switch, bit value to enqueue
//               bit_pop     - consume strobe from downstream
//               bit_out     - head-of-queue bit (0 when empty)
//               bit_valid   - queue non-empty
//               fill        - queue occupancy 0..FIFO_DEPTH
//               overflow    - sticky: a press was dropped on a full queue
//               press_pulse - one cycle per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module input_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEFAULT   // power of two, 2..16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic              sw_raw,
  input  logic              bit_pop,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [FILL_W-1:0] fill,
  output logic              overflow,
  output logic              press_pulse
);

  localparam int              PW        = $clog2(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  logic press_pulse_w;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in (clk_in),
    .reset  (reset),
    .raw_i  (btn_raw),
    .pulse_o(press_pulse_w)
  );

  // Switch synchronizer; same depth as the button path
  logic sw_s1_q;
  logic sw_s2_q;

  // FIFO state
  logic [FIFO_DEPTH-1:0] mem_q,    mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]     fill_q,   fill_d;
  logic                  bit_out_q, bit_out_d;
  logic                  valid_q,   valid_d;
  logic                  overflow_q, overflow_d;

  logic full;
  logic pop_en;
  logic push_en;

  always_comb begin
    full       = (fill_q == FILL_FULL);
    pop_en     = bit_pop && valid_q;
    // A pop in the same cycle frees the slot a full queue needs
    push_en    = press_pulse_w && (!full || pop_en);
    overflow_d = overflow_q || (press_pulse_w && full && !pop_en);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    if (push_en) begin
      mem_d[wr_ptr_q] = sw_s2_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_en && !pop_en) begin
      fill_d = fill_q + 1'b1;
    end else if (pop_en && !push_en) begin
      fill_d = fill_q - 1'b1;
    end

    // Head is looked up in the post-write image so a push into an empty
    // (or just-drained) queue shows up on bit_out immediately.
    valid_d   = (fill_d != '0);
    bit_out_d = valid_d ? mem_d[rd_ptr_d] : 1'b0;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sw_s1_q    <= 1'b0;
      sw_s2_q    <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      bit_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sw_s1_q    <= sw_raw;
      sw_s2_q    <= sw_s1_q;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      bit_out_q  <= bit_out_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = valid_q;
  assign fill        = fill_q;
  assign overflow    = overflow_q;
  assign press_pulse = press_pulse_w;

endmodule : input_sequencer
`default_nettype wire
